// File: rtl/result_uart_tx.sv
// Captures low bytes of processor stores in an address window into a FIFO and sends them 8N1 over UART.
// Define UART_PARITY_EN to insert an even-parity bit after the data bits (8E1 framing).
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] WIN_BASE     = 32'h0000_0400,
    parameter int unsigned WIN_WORDS    = 704
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    // Window bounds held at 33 bits so the upper limit can never wrap.
    localparam logic [32:0] WIN_LO = {1'b0, WIN_BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(WIN_WORDS) << 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
`ifdef UART_PARITY_EN
    logic          par_q, par_d;
`endif
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          ovf_q;
    logic [7:0]    mem [FIFO_DEPTH];

    logic in_win, full, push, pop, tick;
    logic unused_hi;

    assign unused_hi = ^WriteData[31:8];
    assign in_win    = MemWrite && ({1'b0, DataAdr} >= WIN_LO) && ({1'b0, DataAdr} < WIN_HI);
    assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
    assign push      = in_win && !full;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign tick      = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= WriteData[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (in_win && full) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pop) begin
                    state_d = S_START;
                    shreg_d = mem[rd_ptr_q];
                    bit_d   = '0;
`ifdef UART_PARITY_EN
                    par_d   = ^mem[rd_ptr_q];
`endif
                end
            end
            S_START: if (tick) state_d = S_DATA;
            S_DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (tick) state_d = S_STOP;
`endif
            S_STOP: if (tick) state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shreg_q[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx = par_q;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_full = full;
    assign overflow  = ovf_q;

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, byte FIFO entries (power of 2, >=2).
REQ-003 The block SHALL have parameter WIN_BASE, default 32'h0000_0400, byte address of the first captured word.
REQ-004 The block SHALL have parameter WIN_WORDS, default 704, number of 32-bit words in the capture window.
REQ-005 The block SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset. Reset is asynchronous and active-low.
REQ-007 The block SHALL have port MemWrite, input, 1, processor store strobe.
REQ-008 The block SHALL have port DataAdr, input, 32, processor store byte address.
REQ-009 The block SHALL have port WriteData, input, 32, processor store data.
REQ-010 The block SHALL have port tx, output, 1, UART serial line, idle high.
REQ-011 The block SHALL have port busy, output, 1, high while the FSM is not IDLE or the FIFO is non-empty.
REQ-012 The block SHALL have port fifo_full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-013 The block SHALL have port overflow, output, 1, sticky flag: a capture was dropped.

Function
REQ-014 Capture SHALL occur on a rising edge where MemWrite=1 and WIN_BASE <= DataAdr < WIN_BASE+4*WIN_WORDS (unsigned 32-bit compare, no wrap).
REQ-015 A capture SHALL push WriteData[7:0] into the FIFO; WriteData[31:8] and DataAdr[1:0] are ignored.
REQ-016 A capture while fifo_full=1 SHALL be dropped and set overflow, even if a pop occurs on the same edge.
REQ-017 Stores outside the window SHALL have no effect.
REQ-018 The FIFO SHALL be first-in first-out; pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL range 0..FIFO_DEPTH.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-020 IDLE->START SHALL occur on the edge where the FIFO is non-empty; that edge pops the head byte into the shift register.
REQ-021 A byte captured at edge N into an empty FIFO with the FSM in IDLE SHALL drive tx low from edge N+1.
REQ-022 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-023 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, then go to PARITY or STOP.
REQ-024 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-025 Back-to-back bytes SHALL have exactly one IDLE cycle between the stop bit and the next start bit.
REQ-026 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and reload at each bit boundary.
REQ-027 A capture and a pop on the same edge with the FIFO not full SHALL both take effect; occupancy SHALL be unchanged.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, tx=1, busy=0, fifo_full=0, overflow=0, empty FIFO, counters zero.
REQ-029 Reset mid-frame SHALL abort the frame; tx SHALL return to 1 with no further bits sent.
REQ-030 After rst deasserts, captures SHALL be accepted from the first rising edge.
REQ-031 overflow SHALL clear only on reset.

Configuration
REQ-032 With macro UART_PARITY_EN defined, PARITY SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frames are 11 bits.
REQ-033 Without UART_PARITY_EN, the PARITY state and logic SHALL not exist; DATA goes directly to STOP; frames are 10 bits.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Single store to 0x400 with data 0x0000_00A5 -> tx low from the next edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then 4 high cycles; busy falls after STOP.
REQ-035 Stores to 0x3FC and 0x400+4*704 -> tx stays 1, busy stays 0.
REQ-036 Six consecutive in-window stores 0x01..0x06 on consecutive edges -> 0x01 is popped at once, 0x02..0x05 fill the FIFO, 0x06 is dropped; overflow=1; serial output is 01,02,03,04,05 with one idle cycle between frames.
REQ-037 rst pulsed low during the DATA bits of 0x3C -> tx=1 immediately, FIFO empty, no remaining bits; a new store of 0x55 then transmits cleanly.
REQ-038 UART_PARITY_EN defined, byte 0x07 -> parity bit 1 after the data bits; byte 0x03 -> parity bit 0; frame is 44 cycles.
